// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared constants, state encoding and opcode helpers for alu_seq
//
// Purpose : opcode constants, FSM state encoding, unit count, unit bus width
//           and the flag bit positions inside the 36-bit unit bus word.
// Ports   : none (package).
package alu_seq_pkg;

   localparam int unsigned NUM_UNITS = 12;
   localparam int unsigned BUS_W     = 36;

   // Flag positions within {N,Z,C,V,result[31:0]}
   localparam int unsigned FLAG_N = 35;
   localparam int unsigned FLAG_Z = 34;
   localparam int unsigned FLAG_C = 33;
   localparam int unsigned FLAG_V = 32;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_SHR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_ROR = 4'd6;
   localparam logic [3:0] OP_ROL = 4'd7;
   localparam logic [3:0] OP_NEG = 4'd8;
   localparam logic [3:0] OP_NOT = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;
   localparam logic [3:0] OP_DIV = 4'd11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_MULTI = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/unit-bus/result bundle between a requester and alu_seq
//
// Purpose : groups the operation request, the shared unit bus and the
//           sequencer outputs so they travel as one port.
// Signals : start, opcode[3:0], unit_bus[35:0]   (master -> slave)
//           unit_en[11:0], ready, done, err,
//           result_q[35:0]                        (slave -> master)
// Modports: master = requester / testbench side, slave = alu_seq.
interface alu_seq_if;
   import alu_seq_pkg::*;

   logic                 start;
   logic [3:0]           opcode;
   logic [BUS_W-1:0]     unit_bus;
   logic [NUM_UNITS-1:0] unit_en;
   logic                 ready;
   logic                 done;
   logic                 err;
   logic [BUS_W-1:0]     result_q;

   modport master (
      output start, opcode, unit_bus,
      input  unit_en, ready, done, err, result_q
   );

   modport slave (
      input  start, opcode, unit_bus,
      output unit_en, ready, done, err, result_q
   );

endinterface

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode decoder for alu_seq
//
// Purpose : maps an opcode to a one-hot unit enable, a legal flag and a
//           multicycle flag. Build option: ALU_SEQ_MULDIV_EN makes MUL/DIV
//           legal; without it they decode as illegal with no enable bit.
// Ports   : opcode[3:0]  in   operation code
//           onehot[11:0] out  enable pattern for the selected unit
//           legal        out  opcode may be executed
//           multi        out  opcode is MUL or DIV (class, independent of legal)
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [3:0]           opcode,
   output logic [NUM_UNITS-1:0] onehot,
   output logic                 legal,
   output logic                 multi
);

   always_comb begin
      onehot = '0;
      legal  = 1'b0;
      multi  = is_multicycle(opcode);
      if (opcode <= OP_NOT) begin
         legal  = 1'b1;
         onehot = NUM_UNITS'(1) << opcode;
      end
`ifdef ALU_SEQ_MULDIV_EN
      else if (multi) begin
         legal  = 1'b1;
         onehot = NUM_UNITS'(1) << opcode;
      end
`endif
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - operation sequencer driving one-hot enables of external ALU units
//
// Purpose : accepts an opcode, enables the matching unit for one cycle
//           (or MULDIV_CYCLES cycles for MUL/DIV), captures the shared unit
//           bus and pulses done. Illegal opcodes complete at once with err.
//           Build option: ALU_SEQ_MULDIV_EN enables the MUL/DIV multicycle
//           path; without it MUL/DIV are rejected and no counter exists.
// Ports   : clock     in   rising-edge clock
//           clear     in   asynchronous active-high reset
//           io        slave modport of alu_seq_if (start, opcode, unit_bus in;
//                     unit_en, ready, done, err, result_q out)
module alu_seq #(
   parameter int unsigned MULDIV_CYCLES = 32
) (
   input  logic     clock,
   input  logic     clear,
   alu_seq_if.slave io
);
   import alu_seq_pkg::*;

   if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 63) begin : g_bad_cycles
      $error("alu_seq: MULDIV_CYCLES must be within 2..63");
   end

   state_t               state;
   logic [NUM_UNITS-1:0] dec_onehot;
   logic                 dec_legal;
   logic                 dec_multi;

`ifdef ALU_SEQ_MULDIV_EN
   // Counts down the remaining enable cycles; zero marks the capture cycle.
   logic [5:0] cnt;
`endif

   alu_seq_decode u_decode (
      .opcode (io.opcode),
      .onehot (dec_onehot),
      .legal  (dec_legal),
      .multi  (dec_multi)
   );

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state       <= S_IDLE;
         io.unit_en  <= '0;
         io.ready    <= 1'b1;
         io.done     <= 1'b0;
         io.err      <= 1'b0;
         io.result_q <= '0;
`ifdef ALU_SEQ_MULDIV_EN
         cnt         <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               io.done <= 1'b0;
               io.err  <= 1'b0;
               if (io.start) begin
                  io.ready <= 1'b0;
                  if (!dec_legal) begin
                     // Rejected: skip straight to DONE, result_q untouched.
                     state   <= S_DONE;
                     io.done <= 1'b1;
                     io.err  <= 1'b1;
                  end else if (dec_multi) begin
`ifdef ALU_SEQ_MULDIV_EN
                     state      <= S_MULTI;
                     io.unit_en <= dec_onehot;
                     cnt        <= 6'(MULDIV_CYCLES - 1);
`else
                     state   <= S_DONE;
                     io.done <= 1'b1;
                     io.err  <= 1'b1;
`endif
                  end else begin
                     state      <= S_EXEC;
                     io.unit_en <= dec_onehot;
                  end
               end
            end
            S_EXEC: begin
               io.unit_en  <= '0;
               io.result_q <= io.unit_bus;
               io.done     <= 1'b1;
               state       <= S_DONE;
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_MULTI: begin
               if (cnt == 6'd0) begin
                  io.unit_en  <= '0;
                  io.result_q <= io.unit_bus;
                  io.done     <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
`endif
            S_DONE: begin
               io.done  <= 1'b0;
               io.err   <= 1'b0;
               io.ready <= 1'b1;
               state    <= S_IDLE;
            end
            default: begin
               state      <= S_IDLE;
               io.unit_en <= '0;
               io.done    <= 1'b0;
               io.err     <= 1'b0;
               io.ready   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking randomized bench for alu_seq
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MULDIV_ON = 1'b1;
`else
   localparam bit MULDIV_ON = 1'b0;
`endif
   localparam int MC = 32;

   logic clock;
   logic clear;
   int   cyc;
   int   n_checks;
   int   n_errors;
   logic [35:0] res_model;

   alu_seq_if bus_if ();

   alu_seq #(.MULDIV_CYCLES(MC)) dut (
      .clock (clock),
      .clear (clear),
      .io    (bus_if)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not reach summary");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [35:0] rand36();
      return {4'($urandom), 32'($urandom)};
   endfunction

   // Expected behaviour from the operation rules: legal ops enable their unit
   // for 1 (or MC for MUL/DIV) cycles, done follows the last enable cycle,
   // rejected ops finish one cycle after acceptance. busy_op is what the
   // requester presents while the sequencer is busy (start held = hold).
   task automatic run_op(input logic [3:0] op, input logic [35:0] bus,
                         input bit hold, input logic [3:0] busy_op);
      bit          multi;
      bit          legal;
      int          n_en;
      logic [11:0] exp_en;
      multi  = (op == 4'd10) || (op == 4'd11);
      legal  = (op <= 4'd9) || (multi && MULDIV_ON);
      n_en   = !legal ? 0 : (multi ? MC : 1);
      exp_en = legal ? (12'(1) << op) : 12'h000;
      check("ready_idle", 64'(bus_if.ready), 64'd1);
      bus_if.start    = 1'b1;
      bus_if.opcode   = op;
      bus_if.unit_bus = rand36();
      for (int k = 1; k <= n_en + 1; k++) begin
         @(negedge clock);
         bus_if.start    = hold;
         bus_if.opcode   = busy_op;
         bus_if.unit_bus = (k == n_en) ? bus : rand36();
         check($sformatf("unit_en_op%0d_k%0d", op, k), 64'(bus_if.unit_en),
               64'((k <= n_en) ? exp_en : 12'h000));
         check($sformatf("done_op%0d_k%0d", op, k), 64'(bus_if.done), 64'(k == n_en + 1));
         check("ready_busy", 64'(bus_if.ready), 64'd0);
         if (k == n_en + 1)
            check($sformatf("err_op%0d", op), 64'(bus_if.err), 64'(!legal));
      end
      if (legal) res_model = bus;
      @(negedge clock);
      check("ready_after", 64'(bus_if.ready), 64'd1);
      check("done_after", 64'(bus_if.done), 64'd0);
      check("unit_en_after", 64'(bus_if.unit_en), 64'd0);
      check($sformatf("result_q_op%0d", op), 64'(bus_if.result_q), 64'(res_model));
   endtask

   task automatic idle_gap(input int g);
      bus_if.start = 1'b0;
      for (int i = 0; i < g; i++) begin
         @(negedge clock);
         check("gap_ready", 64'(bus_if.ready), 64'd1);
         check("gap_unit_en", 64'(bus_if.unit_en), 64'd0);
         check("gap_result_q", 64'(bus_if.result_q), 64'(res_model));
      end
   endtask

   task automatic abort_test();
      logic [3:0] op;
      int         k_abort;
      op      = MULDIV_ON ? 4'd10 : 4'd0;
      k_abort = MULDIV_ON ? 10 : 1;
      bus_if.start    = 1'b1;
      bus_if.opcode   = op;
      bus_if.unit_bus = rand36();
      for (int k = 1; k <= k_abort; k++) begin
         @(negedge clock);
         bus_if.start    = 1'b0;
         bus_if.unit_bus = rand36();
         check("abort_unit_en", 64'(bus_if.unit_en), 64'(12'(1) << op));
      end
      #1 clear = 1'b1;
      #1;
      res_model = '0;
      check("abort_unit_en_cleared", 64'(bus_if.unit_en), 64'd0);
      check("abort_result_q_cleared", 64'(bus_if.result_q), 64'd0);
      check("abort_done", 64'(bus_if.done), 64'd0);
      check("abort_ready", 64'(bus_if.ready), 64'd1);
      @(negedge clock);
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("post_abort_done", 64'(bus_if.done), 64'd0);
         check("post_abort_ready", 64'(bus_if.ready), 64'd1);
         check("post_abort_unit_en", 64'(bus_if.unit_en), 64'd0);
      end
   endtask

   initial begin
      int c0;
      int c1;
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      res_model = '0;
      clear           = 1'b1;
      bus_if.start    = 1'b0;
      bus_if.opcode   = 4'd0;
      bus_if.unit_bus = '0;
      #1;
      check("rst_unit_en", 64'(bus_if.unit_en), 64'd0);
      check("rst_done", 64'(bus_if.done), 64'd0);
      check("rst_err", 64'(bus_if.err), 64'd0);
      check("rst_result_q", 64'(bus_if.result_q), 64'd0);
      @(negedge clock);
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      check("rst_ready", 64'(bus_if.ready), 64'd1);

      run_op(4'd3, 36'h0_FFFF0000, 1'b0, 4'd0);
      idle_gap(2);
      run_op(4'd13, rand36(), 1'b0, 4'd0);
      idle_gap(1);
      run_op(4'd10, 36'h4_00000000, 1'b0, 4'd0);
      idle_gap(1);

      // Start held with ADD while busy: ignored, then ADD taken from IDLE.
      run_op(MULDIV_ON ? 4'd11 : 4'd1, rand36(), 1'b1, 4'd0);
      run_op(4'd0, rand36(), 1'b0, 4'd0);
      idle_gap(1);

      // Back-to-back ADD then SUB with start tied high.
      c0 = cyc;
      run_op(4'd0, rand36(), 1'b1, 4'd1);
      c1 = cyc;
      run_op(4'd1, rand36(), 1'b0, 4'd0);
      check("b2b_spacing", 64'(c1 - c0), 64'd3);
      idle_gap(1);

      for (int n = 0; n < 40; n++) begin
         run_op(4'($urandom_range(0, 15)), rand36(), 1'b0, 4'($urandom_range(0, 15)));
         idle_gap($urandom_range(0, 2));
      end

      run_op(4'd2, rand36(), 1'b0, 4'd0);
      abort_test();
      run_op(4'd5, rand36(), 1'b0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter MULDIV_CYCLES, default 32: enable-hold cycles for MUL/DIV (legal range 2..63).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port clear  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  operation request; sampled only while ready=1.
REQ-005 SHALL have port opcode  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 NEG, 9 NOT, 10 MUL, 11 DIV; 12-15 illegal.
REQ-006 SHALL have port unit_bus  in  36  shared unit output {N,Z,C,V,result[31:0]}, driven only by the enabled unit.
REQ-007 SHALL have port unit_en  out  12  one-hot unit enables, bit index = opcode.
REQ-008 SHALL have port ready  out  1  high when idle and able to accept start.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port err  out  1  high with done when the operation was rejected.
REQ-011 SHALL have port result_q  out  36  last captured {N,Z,C,V,result}.

Function
REQ-012 SHALL implement states IDLE, EXEC, MULTI, DONE; all outputs registered.
REQ-013 IDLE: ready=1; start=1 with legal single-cycle opcode -> EXEC; with MUL/DIV -> MULTI; with illegal opcode -> DONE with err set.
REQ-014 EXEC: unit_en bit asserted for exactly one cycle; unit_bus captured into result_q at that cycle's closing edge; -> DONE.
REQ-015 MULTI: unit_en bit held MULDIV_CYCLES cycles via cycle counter; unit_bus captured on the final cycle only; -> DONE.
REQ-016 DONE: done=1 for one cycle, err per REQ-013, ready=0, unit_en=0; -> IDLE.
REQ-017 Latency start-to-done: 2 cycles single-cycle op, MULDIV_CYCLES+1 for MUL/DIV, 1 for rejected op.
REQ-018 start while ready=0 SHALL be ignored, not queued.
REQ-019 Rejected operation SHALL leave result_q unchanged and assert no unit_en bit.
REQ-020 At most one unit_en bit SHALL be high in any cycle; none outside EXEC/MULTI.
REQ-021 Counter SHALL reload on MULTI entry; no wrap carries into the next operation.

Reset
REQ-022 clear SHALL force IDLE, unit_en=0, done=0, err=0, ready=1 (after deassertion), result_q=0, counter=0 immediately, including mid-EXEC/MULTI; the aborted op SHALL produce no done.

Configuration
REQ-023 With ALU_SEQ_MULDIV_EN defined, opcodes 10/11 SHALL be sequenced per REQ-015.
REQ-024 Without ALU_SEQ_MULDIV_EN, opcodes 10/11 SHALL be rejected as illegal, MULTI and the counter SHALL be absent, unit_en[11:10] tied 0.

Structure
REQ-025 Package alu_seq_pkg SHALL hold opcode constants, state encoding, unit count (12), bus width (36) and flag bit positions.
REQ-026 Sub-module alu_seq_decode SHALL map opcode -> one-hot enable, legal, multicycle (combinational).

Verification
REQ-027 OR: start, opcode=3, unit_bus=36'h0_FFFF0000 -> unit_en=12'h008 one cycle, done 2 cycles after start, result_q=36'h0_FFFF0000, err=0.
REQ-028 Illegal opcode=13 -> done+err next cycle, unit_en=0, result_q unchanged.
REQ-029 MUL (MULDIV_EN, MULDIV_CYCLES=32), unit_bus=36'h4_00000000 on final cycle -> unit_en=12'h400 for 32 cycles, done at cycle 33, result_q=36'h4_00000000; without macro -> err.
REQ-030 start held high during MULTI with opcode=0 -> ignored; ADD runs only after next IDLE.
REQ-031 clear asserted at MULTI cycle 10 -> unit_en=0 and result_q=0 immediately, no done, ready=1 after release.
REQ-032 Back-to-back ADD then SUB with start tied high -> accepted every 3 cycles, unit_en never multi-hot.
